// File: rtl/syn_vga_drvr_lb_pkg.sv
// Shared constants and types for the VGA driver local-bus slave.
// Register addresses, bit positions and the CTRL register layout.
package syn_vga_drvr_lb_pkg;

  localparam logic [1:0] VGA_LB_CTRL_ADDR    = 2'd0;
  localparam logic [1:0] VGA_LB_STATUS_ADDR  = 2'd1;
  localparam logic [1:0] VGA_LB_OVF_CNT_ADDR = 2'd2;
  localparam logic [1:0] VGA_LB_UNF_CNT_ADDR = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_OVF_IE_BIT   = 1;
  localparam int CTRL_UNF_IE_BIT   = 2;
  localparam int CTRL_AUTO_DIS_BIT = 3;

  localparam int STAT_OVF_BIT = 0;
  localparam int STAT_UNF_BIT = 1;

  typedef struct packed {
    logic auto_dis;
    logic unf_irq_en;
    logic ovf_irq_en;
    logic drvr_en;
  } vga_lb_ctrl_t;

endpackage

// File: rtl/syn_sat_edge_cntr.sv
// Rising-edge detector feeding a saturating event counter with clear.
// A clear coinciding with an event leaves the counter at one.
module syn_sat_edge_cntr #(
  parameter int CNT_W = 16
) (
  input  logic             clk_ir,
  input  logic             rst_ih,
  input  logic             i_lvl,
  input  logic             i_clr,
  output logic             o_evt,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign o_evt = i_lvl & ~r_prev;
  assign o_cnt = r_cnt;

  always_comb begin
    w_base    = i_clr ? '0 : r_cnt;
    w_cnt_nxt = w_base;
    if (o_evt && !(&w_base))
      w_cnt_nxt = w_base + CNT_W'(1);
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_lvl;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/syn_vga_drvr_lb.sv
// Local-bus register slave for the VGA driver: control, sticky
// line-buffer status, event counters and a maskable interrupt.
import syn_vga_drvr_lb_pkg::*;

module syn_vga_drvr_lb #(
  parameter int LB_DATA_W = 32,
  parameter int LB_ADDR_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_ir,
  input  logic                 rst_ih,
  input  logic                 lb_wr_en,
  input  logic                 lb_rd_en,
  input  logic [LB_ADDR_W-1:0] lb_addr,
  input  logic [LB_DATA_W-1:0] lb_wr_data,
  output logic                 lb_rd_valid,
  output logic [LB_DATA_W-1:0] lb_rd_data,
  output logic                 vga_drvr_en,
  input  logic                 bffr_overflow,
  input  logic                 bffr_underflow,
  output logic                 irq
);

  logic [1:0]           w_addr;
  logic                 w_wr_ctrl;
  logic                 w_wr_stat;
  logic                 w_wr_ovf;
  logic                 w_wr_unf;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;
  logic                 w_ovf_w1c;
  logic                 w_unf_w1c;
  logic [CNT_W-1:0]     w_ovf_cnt;
  logic [CNT_W-1:0]     w_unf_cnt;
  logic [LB_DATA_W-1:0] w_rd_mux;
  logic                 w_unused;

  vga_lb_ctrl_t r_ctrl;
  vga_lb_ctrl_t w_ctrl_wr;
  vga_lb_ctrl_t w_ctrl_nxt;

  logic                 r_ovf_stk;
  logic                 r_unf_stk;
  logic                 r_irq;
  logic                 r_rd_valid;
  logic [LB_DATA_W-1:0] r_rd_data;

  assign w_addr   = lb_addr[1:0];
  assign w_unused = ^{lb_addr[LB_ADDR_W-1:2],
                      lb_wr_data[LB_DATA_W-1:4]};

  assign w_wr_ctrl = lb_wr_en && (w_addr == VGA_LB_CTRL_ADDR);
  assign w_wr_stat = lb_wr_en && (w_addr == VGA_LB_STATUS_ADDR);
  assign w_wr_ovf  = lb_wr_en && (w_addr == VGA_LB_OVF_CNT_ADDR);
  assign w_wr_unf  = lb_wr_en && (w_addr == VGA_LB_UNF_CNT_ADDR);

  assign w_ovf_w1c = w_wr_stat & lb_wr_data[STAT_OVF_BIT];
  assign w_unf_w1c = w_wr_stat & lb_wr_data[STAT_UNF_BIT];

  syn_sat_edge_cntr #(
    .CNT_W (CNT_W)
  ) u_ovf_cntr (
    .clk_ir (clk_ir),
    .rst_ih (rst_ih),
    .i_lvl  (bffr_overflow),
    .i_clr  (w_wr_ovf),
    .o_evt  (w_ovf_evt),
    .o_cnt  (w_ovf_cnt)
  );

  syn_sat_edge_cntr #(
    .CNT_W (CNT_W)
  ) u_unf_cntr (
    .clk_ir (clk_ir),
    .rst_ih (rst_ih),
    .i_lvl  (bffr_underflow),
    .i_clr  (w_wr_unf),
    .o_evt  (w_unf_evt),
    .o_cnt  (w_unf_cnt)
  );

  // Hardware auto-disable overrides a same-cycle software enable.
  always_comb begin
    w_ctrl_wr            = '0;
    w_ctrl_wr.drvr_en    = lb_wr_data[CTRL_EN_BIT];
    w_ctrl_wr.ovf_irq_en = lb_wr_data[CTRL_OVF_IE_BIT];
    w_ctrl_wr.unf_irq_en = lb_wr_data[CTRL_UNF_IE_BIT];
    w_ctrl_wr.auto_dis   = lb_wr_data[CTRL_AUTO_DIS_BIT];
    w_ctrl_nxt = r_ctrl;
    if (w_wr_ctrl)
      w_ctrl_nxt = w_ctrl_wr;
    if (r_ctrl.auto_dis && (w_ovf_evt || w_unf_evt))
      w_ctrl_nxt.drvr_en = 1'b0;
  end

  always_comb begin
    w_rd_mux = '0;
    unique case (w_addr)
      VGA_LB_CTRL_ADDR:    w_rd_mux = LB_DATA_W'(r_ctrl);
      VGA_LB_STATUS_ADDR: begin
        w_rd_mux[STAT_OVF_BIT] = r_ovf_stk;
        w_rd_mux[STAT_UNF_BIT] = r_unf_stk;
      end
      VGA_LB_OVF_CNT_ADDR: w_rd_mux = LB_DATA_W'(w_ovf_cnt);
      VGA_LB_UNF_CNT_ADDR: w_rd_mux = LB_DATA_W'(w_unf_cnt);
      default:             w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_ctrl    <= '0;
      r_ovf_stk <= 1'b0;
      r_unf_stk <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_ovf_stk <= w_ovf_evt | (r_ovf_stk & ~w_ovf_w1c);
      r_unf_stk <= w_unf_evt | (r_unf_stk & ~w_unf_w1c);
      r_irq     <= (r_ovf_stk & r_ctrl.ovf_irq_en) |
                   (r_unf_stk & r_ctrl.unf_irq_en);
    end
  end

  // Read data samples pre-write state and holds until the next read.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= lb_rd_en;
      if (lb_rd_en)
        r_rd_data <= w_rd_mux;
    end
  end

  assign lb_rd_valid = r_rd_valid;
  assign lb_rd_data  = r_rd_data;
  assign vga_drvr_en = r_ctrl.drvr_en;
  assign irq         = r_irq;

endmodule

// File: tb/tb_syn_vga_drvr_lb.sv
// Self-checking bench for syn_vga_drvr_lb: directed table,
// corner sequences and randomized traffic against a reference model.
module tb_syn_vga_drvr_lb;

  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wd = '0;
  logic        ov = 1'b0;
  logic        un = 1'b0;
  logic        rv;
  logic [31:0] rdd;
  logic        en;
  logic        irq;

  logic        wr4 = 1'b0;
  logic        rd4 = 1'b0;
  logic [7:0]  addr4 = '0;
  logic [31:0] wd4 = '0;
  logic        ov4 = 1'b0;
  logic        un4 = 1'b0;
  logic        rv4;
  logic [31:0] rdd4;
  logic        en4;
  logic        irq4;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  m_ctrl;
  logic        m_os, m_us, m_po, m_pu, m_irq, m_rv;
  int          m_oc, m_uc;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  syn_vga_drvr_lb u_dut (
    .clk_ir         (clk),
    .rst_ih         (rst),
    .lb_wr_en       (wr_en),
    .lb_rd_en       (rd_en),
    .lb_addr        (addr),
    .lb_wr_data     (wd),
    .lb_rd_valid    (rv),
    .lb_rd_data     (rdd),
    .vga_drvr_en    (en),
    .bffr_overflow  (ov),
    .bffr_underflow (un),
    .irq            (irq)
  );

  syn_vga_drvr_lb #(
    .CNT_W (4)
  ) u_dut4 (
    .clk_ir         (clk),
    .rst_ih         (rst),
    .lb_wr_en       (wr4),
    .lb_rd_en       (rd4),
    .lb_addr        (addr4),
    .lb_wr_data     (wd4),
    .lb_rd_valid    (rv4),
    .lb_rd_data     (rdd4),
    .vga_drvr_en    (en4),
    .bffr_overflow  (ov4),
    .bffr_underflow (un4),
    .irq            (irq4)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  a;
    logic [31:0] d;
    logic        o;
    logic        u;
    logic        e_en;
    logic        e_irq;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic wr, input logic rd, input logic [1:0] a,
    input logic [31:0] d, input logic o, input logic u,
    input logic e_en, input logic e_irq, input logic e_rv,
    input logic [31:0] e_rd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.d = d; v.o = o; v.u = u;
    v.e_en = e_en; v.e_irq = e_irq; v.e_rv = e_rv; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_os = 0; m_us = 0; m_po = 0; m_pu = 0;
    m_irq = 0; m_rv = 0; m_oc = 0; m_uc = 0; m_rd = '0;
  endtask

  // Register-level behaviour for one clock edge.
  task automatic model_step(input logic w, input logic r,
    input logic [1:0] a, input logic [31:0] d,
    input logic o, input logic u);
    logic oe, ue, old_ad;
    logic [31:0] mux;
    oe = o & ~m_po;
    ue = u & ~m_pu;
    case (a)
      2'd0:    mux = {28'b0, m_ctrl};
      2'd1:    mux = {30'b0, m_us, m_os};
      2'd2:    mux = 32'(m_oc);
      default: mux = 32'(m_uc);
    endcase
    m_irq  = (m_os & m_ctrl[1]) | (m_us & m_ctrl[2]);
    old_ad = m_ctrl[3];
    if (w && a == 2'd0) m_ctrl = d[3:0];
    if (old_ad && (oe || ue)) m_ctrl[0] = 1'b0;
    if (w && a == 2'd1 && d[0]) m_os = 1'b0;
    if (w && a == 2'd1 && d[1]) m_us = 1'b0;
    if (oe) m_os = 1'b1;
    if (ue) m_us = 1'b1;
    if (w && a == 2'd2) m_oc = 0;
    if (w && a == 2'd3) m_uc = 0;
    if (oe && m_oc < CMAX) m_oc++;
    if (ue && m_uc < CMAX) m_uc++;
    m_po = o;
    m_pu = u;
    m_rv = r;
    if (r) m_rd = mux;
  endtask

  task automatic cyc(input logic w, input logic r,
    input logic [1:0] a, input logic [31:0] d,
    input logic o, input logic u, input logic [5:0] hi);
    wr_en = w; rd_en = r; addr = {hi, a}; wd = d; ov = o; un = u;
    @(posedge clk);
    model_step(w, r, a, d, o, u);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset rd_valid", rv, 0);
    chk("reset rd_data", rdd, 0);
    chk("reset drvr_en", en, 0);
    chk("reset irq", irq, 0);
    chk("reset4 rd_data", rdd4, 0);
    rst = 1'b0;

    tbl.push_back(mk(1,0,0,32'h1,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,     1,0,1,32'h1));
    tbl.push_back(mk(1,0,0,32'h3,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,     1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,     1,1,0,0));
    tbl.push_back(mk(0,1,2,0,0,0,     1,1,1,32'h3));
    tbl.push_back(mk(0,1,1,0,0,0,     1,1,1,32'h1));
    tbl.push_back(mk(1,0,1,32'h1,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(1,0,0,32'h1,0,1, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,     1,0,0,0));
    tbl.push_back(mk(1,0,1,32'h2,0,1, 1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,     1,0,1,32'h2));
    tbl.push_back(mk(0,1,3,0,0,0,     1,0,1,32'h2));
    tbl.push_back(mk(1,0,3,32'h0,0,1, 1,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,0,     1,0,1,32'h1));
    tbl.push_back(mk(1,0,0,32'h8,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,32'h9,1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,     0,0,1,32'h8));
    tbl.push_back(mk(1,1,0,32'h0,0,0, 0,0,1,32'h8));
    tbl.push_back(mk(0,1,0,0,0,0,     0,0,1,32'h0));
    tbl.push_back(mk(0,1,1,0,0,0,     0,0,1,32'h3));
    tbl.push_back(mk(0,1,2,0,0,0,     0,0,1,32'h4));
    tbl.push_back(mk(0,1,3,0,0,0,     0,0,1,32'h1));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d,
          tbl[i].o, tbl[i].u, 6'd0);
      chk($sformatf("row%0d drvr_en", i), en, tbl[i].e_en);
      chk($sformatf("row%0d irq", i), irq, tbl[i].e_irq);
      chk($sformatf("row%0d rd_valid", i), rv, tbl[i].e_rv);
      if (tbl[i].e_rv)
        chk($sformatf("row%0d rd_data", i), rdd, tbl[i].e_rd);
    end

    // Asynchronous reset in the middle of a read.
    cyc(1'b1, 1'b0, 2'd0, 32'h3, 1'b0, 1'b0, 6'd0);
    idle();
    chk("prerst drvr_en", en, 1);
    chk("prerst irq", irq, 1);
    rd_en = 1'b1;
    addr  = 8'd1;
    #3 rst = 1'b1;
    #1;
    chk("midrst rd_valid", rv, 0);
    chk("midrst rd_data", rdd, 0);
    chk("midrst drvr_en", en, 0);
    chk("midrst irq", irq, 0);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst no valid", rv, 0);
    #3 rst = 1'b0;
    model_reset();
    idle();
    chk("postrst no valid", rv, 0);
    cyc(1'b0, 1'b1, 2'd1, 32'd0, 1'b0, 1'b0, 6'd0);
    chk("postrst status valid", rv, 1);
    chk("postrst status", rdd, 0);

    // Saturation on the 4-bit counter instance.
    for (int i = 0; i < 20; i++) begin
      ov4 = 1'b1;
      idle();
      ov4 = 1'b0;
      idle();
    end
    rd4 = 1'b1;
    addr4 = 8'd2;
    idle();
    rd4 = 1'b0;
    chk("sat valid", rv4, 1);
    chk("sat ovf_cnt", rdd4, 32'hF);
    wr4 = 1'b1;
    rd4 = 1'b1;
    idle();
    wr4 = 1'b0;
    idle();
    rd4 = 1'b0;
    chk("sat clear cnt", rdd4, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic w, r, o, u;
      logic [1:0] a;
      logic [31:0] d;
      w = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 1) == 1;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      o = ($urandom_range(0, 3) == 0) ? ~ov : ov;
      u = ($urandom_range(0, 3) == 0) ? ~un : un;
      cyc(w, r, a, d, o, u, 6'($urandom));
      chk("rnd drvr_en", en, m_ctrl[0]);
      chk("rnd irq", irq, m_irq);
      chk("rnd rd_valid", rv, m_rv);
      chk("rnd rd_data", rdd, m_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/syn_vga_drvr_lb.md
# syn_vga_drvr_lb

Local-bus register slave for the VGA driver, and the `lb` end of the driver/line-buffer status interface. It owns the `vga_drvr_en` control bit that the line buffer and the FSM consume. It captures the line buffer's `bffr_overflow` and `bffr_underflow` indications into sticky status bits and saturating event counters, and raises a maskable interrupt. It sits between the system local bus and the VGA driver core, in the same clock domain as the core.

## Interface
- `LB_DATA_W`, 32, local-bus data width; must be at least `CNT_W`.
- `LB_ADDR_W`, 8, local-bus address width; upper bits are decoded upstream and only `addr[1:0]` is used here.
- `CNT_W`, 16, width of each event counter.

Ports:
- `clk_ir`  in  1  single clock for the block.
- `rst_ih`  in  1  reset, asynchronous and active-high.
- `lb_wr_en`  in  1  one-cycle write strobe.
- `lb_rd_en`  in  1  one-cycle read strobe.
- `lb_addr`  in  `LB_ADDR_W`  register address.
- `lb_wr_data`  in  `LB_DATA_W`  write data.
- `lb_rd_valid`  out  1  read data valid strobe.
- `lb_rd_data`  out  `LB_DATA_W`  read data.
- `vga_drvr_en`  out  1  driver enable, to the line buffer and the FSM.
- `bffr_overflow`  in  1  overflow level from the line buffer, synchronous to `clk_ir`.
- `bffr_underflow`  in  1  underflow level from the line buffer, synchronous to `clk_ir`.
- `irq`  out  1  registered interrupt.

## Operation
Register map (`addr[1:0]`):
- 0 CTRL (RW)
  - bit0 `vga_drvr_en`.
  - bit1 `ovf_irq_en`.
  - bit2 `unf_irq_en`.
  - bit3 `auto_dis`: hardware clears bit0 on an overflow or underflow event.
- 1 STATUS (W1C)
  - bit0 overflow sticky.
  - bit1 underflow sticky.
- 2 OVF_CNT (RO): count of overflow events. Any write clears it.
- 3 UNF_CNT (RO): count of underflow events. Any write clears it.

Event definition:
- An event is a rising edge of the respective input, detected against a registered previous value. A held level counts once.
- Each event sets its sticky bit and increments its counter.
- Counters saturate at all-ones; they never wrap.

Other behaviour:
- Unused read bits return 0.
- `irq` = (ovf sticky & `ovf_irq_en`) | (unf sticky & `unf_irq_en`), registered.
- Reset values: all CTRL bits 0, stickies 0, counters 0, edge-detect history 0, `vga_drvr_en` 0, `irq` 0, `lb_rd_valid` 0, `lb_rd_data` 0.

Boundary rules:
- Event and W1C on the same bit in the same cycle: the event wins, and the bit stays 1.
- Event and counter-clear in the same cycle: the counter becomes 1.
- Event at saturation: the counter holds at all-ones.
- `auto_dis` event and a CTRL write setting bit0 in the same cycle: the hardware clear wins, and bit0 ends at 0. Other CTRL bits take the write data.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- Reset asserted mid-operation: all state is immediately at its reset value. A read in flight is dropped, and no `lb_rd_valid` is issued for it.

## Timing
- Write: the register updates on the clock edge where `lb_wr_en`=1. `vga_drvr_en` changes in the cycle after the strobe.
- Read: `lb_rd_valid` pulses for exactly one cycle, one cycle after `lb_rd_en`. `lb_rd_data` is valid with it and holds its value until the next read.
- Back-to-back reads on every cycle are supported, one response per cycle.
- Event path: input rises at cycle N; the edge is detected and the sticky/counter update at edge N+1; `irq` asserts at N+2.
- W1C path: W1C at cycle N clears the sticky at N+1; `irq` deasserts at N+2.

## Structure
- Package `syn_vga_drvr_lb_pkg` holds:
  - the address constants `VGA_LB_CTRL_ADDR`, `VGA_LB_STATUS_ADDR`, `VGA_LB_OVF_CNT_ADDR`, `VGA_LB_UNF_CNT_ADDR`;
  - the CTRL and STATUS bit-index constants;
  - a packed struct typedef for CTRL.
- Sub-module `syn_sat_edge_cntr` (parameter `CNT_W`) contains the edge detect, event pulse, saturating counter and clear. It is instantiated twice, once for overflow and once for underflow.
- The top level holds the bus decode, CTRL, stickies, the `irq` register and the read mux.

## Test plan
- Reset: assert `rst_ih` asynchronously mid-read → all outputs return to 0 immediately, and no `lb_rd_valid` is issued for the dropped read.
- CTRL: write 0x1 to addr 0 → `vga_drvr_en`=1 the next cycle; read addr 0 → `lb_rd_data`=0x1 with `lb_rd_valid` one cycle after `lb_rd_en`.
- Events: hold `bffr_overflow` high for 5 cycles, then pulse it twice → OVF_CNT=3 and STATUS=0x1; with `ovf_irq_en`=1, `irq`=1 two cycles after the first rise. W1C 0x1 to addr 1 → `irq` falls two cycles after the write.
- Collisions:
  - An underflow edge in the same cycle as W1C 0x2 → STATUS bit1 stays 1.
  - Counter-clear in the same cycle as an event → UNF_CNT reads 1.
  - `auto_dis`=1, an overflow edge and a CTRL write of 0x9 in the same cycle → `vga_drvr_en` stays 0.
- Saturation: with `CNT_W`=4, drive 20 overflow edges → OVF_CNT=0xF.
- Throughput: reads on 4 consecutive cycles to addr 0,1,2,3 → 4 consecutive `lb_rd_valid` cycles carrying the correct values in order.
